// File: rtl/proto_field_encoder.sv
// Protobuf field encoder: serialises one field (tag varint + payload) per
// handshake onto an 8-bit valid/ready byte stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for a field; field_ready high
// S_TAG     | emitting tag varint bytes ((id<<3)|wire_type)
// S_PAYLOAD | emitting varint / length varint or fixed32/fixed64 bytes
module proto_field_encoder #(
  parameter int IDENTIFIER_SIZE = 4,
  parameter int VALUE_WIDTH     = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       field_valid,
  output logic                       field_ready,
  input  logic [IDENTIFIER_SIZE-1:0] field_id,
  input  logic [2:0]                 field_type,
  input  logic [VALUE_WIDTH-1:0]     field_value,
  input  logic                       field_last,
  output logic                       field_err,
  output logic [7:0]                 out_tdata,
  output logic                       out_tvalid,
  input  logic                       out_tready,
  output logic                       out_tlast
);

  localparam int TAG_W    = IDENTIFIER_SIZE + 3;
  // At least one spare zero bit above the tag keeps the [..:7] slices legal
  // even for tiny identifier widths.
  localparam int TAG_SH_W = ((TAG_W > 7) ? TAG_W : 7) + 1;
  localparam int TAG_PAD  = TAG_SH_W - TAG_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_TAG     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                 state, nxt_state;
  logic [TAG_SH_W-1:0]    tag_sh, nxt_tag, dec_tag;
  logic [VALUE_WIDTH-1:0] val_sh, nxt_val, dec_val;
  logic [2:0]             cnt, nxt_cnt;
  logic [2:0]             len_q, nxt_len, dec_len;
  logic                   fixed_q, nxt_fixed, dec_fixed;
  logic                   last_q, nxt_last;
  logic                   nxt_err;
  logic                   dec_ok;
  logic [2:0]             dec_wt;
  logic                   tag_more, val_more;
  logic [7:0]             nxt_byte;
  logic                   nxt_tlast;

  assign tag_more = |tag_sh[TAG_SH_W-1:7];
  assign val_more = |val_sh[VALUE_WIDTH-1:7];
  assign dec_tag  = {{TAG_PAD{1'b0}}, field_id, dec_wt};

  // Decode field_type into wire type, payload form and the value to encode.
  always_comb begin
    dec_ok    = 1'b1;
    dec_fixed = 1'b0;
    dec_len   = 3'd0;
    dec_wt    = 3'd0;
    dec_val   = field_value;
    case (field_type)
      3'b100: begin
        dec_wt = 3'd0;
      end
      3'b101: begin
        dec_wt  = 3'd0;
        dec_val = {{(VALUE_WIDTH-32){field_value[31]}}, field_value[31:0]};
      end
      3'b001: begin
        dec_wt    = 3'd5;
        dec_fixed = 1'b1;
        dec_len   = 3'd3;
      end
      3'b010: begin
        dec_wt    = 3'd1;
        dec_fixed = 1'b1;
        dec_len   = 3'd7;
      end
      3'b000: begin
        dec_wt = 3'd2;
      end
      default: begin
        dec_ok = 1'b0;
      end
    endcase
  end

  // Next-state and shifter/counter update; everything holds while stalled.
  always_comb begin
    nxt_state = state;
    nxt_tag   = tag_sh;
    nxt_val   = val_sh;
    nxt_cnt   = cnt;
    nxt_len   = len_q;
    nxt_fixed = fixed_q;
    nxt_last  = last_q;
    nxt_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (field_valid && field_ready) begin
          if (dec_ok) begin
            nxt_state = S_TAG;
            nxt_tag   = dec_tag;
            nxt_val   = dec_val;
            nxt_cnt   = 3'd0;
            nxt_len   = dec_len;
            nxt_fixed = dec_fixed;
            nxt_last  = field_last;
          end else begin
            nxt_err = 1'b1;
          end
        end
      end
      S_TAG: begin
        if (out_tready) begin
          if (tag_more) nxt_tag = tag_sh >> 7;
          else          nxt_state = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (out_tready) begin
          if (fixed_q) begin
            if (cnt == len_q) nxt_state = S_IDLE;
            else              nxt_cnt = cnt + 3'd1;
          end else if (val_more) begin
            nxt_val = val_sh >> 7;
          end else begin
            nxt_state = S_IDLE;
          end
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Byte and tlast that will be presented once the next state is registered.
  always_comb begin
    nxt_byte  = 8'h00;
    nxt_tlast = 1'b0;
    case (nxt_state)
      S_TAG: begin
        nxt_byte = {|nxt_tag[TAG_SH_W-1:7], nxt_tag[6:0]};
      end
      S_PAYLOAD: begin
        if (nxt_fixed) begin
          nxt_byte  = nxt_val[{nxt_cnt, 3'b000} +: 8];
          nxt_tlast = nxt_last && (nxt_cnt == nxt_len);
        end else begin
          nxt_byte  = {|nxt_val[VALUE_WIDTH-1:7], nxt_val[6:0]};
          nxt_tlast = nxt_last && !(|nxt_val[VALUE_WIDTH-1:7]);
        end
      end
      default: begin
        nxt_byte  = 8'h00;
        nxt_tlast = 1'b0;
      end
    endcase
  end

  // State, operand registers and registered stream outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      tag_sh      <= '0;
      val_sh      <= '0;
      cnt         <= 3'd0;
      len_q       <= 3'd0;
      fixed_q     <= 1'b0;
      last_q      <= 1'b0;
      field_ready <= 1'b1;
      field_err   <= 1'b0;
      out_tdata   <= 8'h00;
      out_tvalid  <= 1'b0;
      out_tlast   <= 1'b0;
    end else begin
      state       <= nxt_state;
      tag_sh      <= nxt_tag;
      val_sh      <= nxt_val;
      cnt         <= nxt_cnt;
      len_q       <= nxt_len;
      fixed_q     <= nxt_fixed;
      last_q      <= nxt_last;
      field_ready <= (nxt_state == S_IDLE);
      field_err   <= nxt_err;
      out_tdata   <= nxt_byte;
      out_tvalid  <= (nxt_state != S_IDLE);
      out_tlast   <= nxt_tlast;
    end
  end

endmodule

// File: tb/tb_proto_field_encoder.sv
// Directed bench for proto_field_encoder: encodings, backpressure,
// mid-field reset and unsupported types, with hand-computed byte streams.
module tb_proto_field_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        field_valid;
  logic        field_ready;
  logic [3:0]  field_id;
  logic [2:0]  field_type;
  logic [63:0] field_value;
  logic        field_last;
  logic        field_err;
  logic [7:0]  out_tdata;
  logic        out_tvalid;
  logic        out_tready;
  logic        out_tlast;

  int checks = 0;
  int passed = 0;

  logic [7:0] got_data[$];
  logic       got_last[$];

  proto_field_encoder #(.IDENTIFIER_SIZE(4), .VALUE_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .field_valid(field_valid), .field_ready(field_ready),
    .field_id(field_id), .field_type(field_type),
    .field_value(field_value), .field_last(field_last),
    .field_err(field_err),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid),
    .out_tready(out_tready), .out_tlast(out_tlast)
  );

  always #5 clk = ~clk;

  // Called at a negedge; the handshake happens on the following posedge.
  task automatic drive_field(input logic [3:0] id, input logic [2:0] ty,
                             input logic [63:0] v, input logic l);
    field_id = id; field_type = ty; field_value = v; field_last = l;
    field_valid = 1'b1;
    @(negedge clk);
    field_valid = 1'b0; field_id = 4'd0; field_type = 3'd0;
    field_value = 64'd0; field_last = 1'b0;
  endtask

  // Records accepted bytes until out_tvalid drops (bounded).
  task automatic collect(input int max_cycles);
    int n;
    n = 0;
    got_data.delete();
    got_last.delete();
    while (out_tvalid && n < max_cycles) begin
      if (out_tready) begin
        got_data.push_back(out_tdata);
        got_last.push_back(out_tlast);
      end
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset();
    checks++; if (field_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", field_ready); else passed++;
    checks++; if (out_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", out_tvalid); else passed++;
    checks++; if (out_tdata !== 8'h00) $display("FAIL rst_tdata got %h want 00", out_tdata); else passed++;
    checks++; if (out_tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", out_tlast); else passed++;
    checks++; if (field_err !== 1'b0) $display("FAIL rst_err got %b want 0", field_err); else passed++;
  endtask

  task automatic test_encodings();
    logic [3:0]  ids[6]   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd15};
    logic [2:0]  tys[6]   = '{3'b100, 3'b101, 3'b001, 3'b010, 3'b000, 3'b100};
    logic [63:0] vals[6]  = '{64'd150, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_1234_5678,
                              64'h0102_0304_0506_0708, 64'd3, 64'd0};
    logic        lasts[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int          lens[6]  = '{3, 11, 5, 9, 2, 2};
    logic [7:0]  exp_b[32] = '{
      8'h08, 8'h96, 8'h01,
      8'h10, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h01,
      8'h1D, 8'h78, 8'h56, 8'h34, 8'h12,
      8'h21, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
      8'h22, 8'h03,
      8'h78, 8'h00};
    int base;
    logic want_last;
    base = 0;
    for (int f = 0; f < 6; f++) begin
      drive_field(ids[f], tys[f], vals[f], lasts[f]);
      checks++; if (out_tvalid !== 1'b1) $display("FAIL enc%0d_latency tvalid got %b want 1", f, out_tvalid); else passed++;
      collect(40);
      checks++; if (got_data.size() != lens[f]) $display("FAIL enc%0d_count got %0d want %0d", f, got_data.size(), lens[f]); else passed++;
      for (int i = 0; i < lens[f] && i < got_data.size(); i++) begin
        want_last = lasts[f] && (i == lens[f] - 1);
        checks++; if (got_data[i] !== exp_b[base+i]) $display("FAIL enc%0d_byte%0d got %h want %h", f, i, got_data[i], exp_b[base+i]); else passed++;
        checks++; if (got_last[i] !== want_last) $display("FAIL enc%0d_tlast%0d got %b want %b", f, i, got_last[i], want_last); else passed++;
      end
      checks++; if (field_ready !== 1'b1) $display("FAIL enc%0d_ready_after got %b want 1", f, field_ready); else passed++;
      base += lens[f];
    end
  endtask

  task automatic test_backpressure();
    drive_field(4'd1, 3'b100, 64'd150, 1'b0);
    checks++; if (out_tdata !== 8'h08) $display("FAIL bp_tag got %h want 08", out_tdata); else passed++;
    @(negedge clk);
    checks++; if (out_tdata !== 8'h96) $display("FAIL bp_first got %h want 96", out_tdata); else passed++;
    out_tready = 1'b0;
    // Busy encoder must ignore an offered field.
    field_valid = 1'b1; field_id = 4'd7; field_type = 3'b100; field_value = 64'd5;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (out_tvalid !== 1'b1) $display("FAIL bp_hold_valid%0d got %b want 1", c, out_tvalid); else passed++;
      checks++; if (out_tdata !== 8'h96) $display("FAIL bp_hold_data%0d got %h want 96", c, out_tdata); else passed++;
      checks++; if (out_tlast !== 1'b0) $display("FAIL bp_hold_last%0d got %b want 0", c, out_tlast); else passed++;
    end
    field_valid = 1'b0;
    out_tready = 1'b1;
    @(negedge clk);
    checks++; if (out_tdata !== 8'h01 || out_tvalid !== 1'b1) $display("FAIL bp_next got %h/%b want 01/1", out_tdata, out_tvalid); else passed++;
    @(negedge clk);
    checks++; if (out_tvalid !== 1'b0) $display("FAIL bp_end_valid got %b want 0", out_tvalid); else passed++;
    checks++; if (field_ready !== 1'b1) $display("FAIL bp_end_ready got %b want 1", field_ready); else passed++;
  endtask

  task automatic test_reset_mid();
    drive_field(4'd2, 3'b101, 64'h0000_0000_FFFF_FFFF, 1'b1);
    repeat (4) @(negedge clk);
    checks++; if (out_tvalid !== 1'b1) $display("FAIL mid_busy got %b want 1", out_tvalid); else passed++;
    rst_n = 1'b0;
    #1;
    checks++; if (out_tvalid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", out_tvalid); else passed++;
    checks++; if (field_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", field_ready); else passed++;
    checks++; if (out_tlast !== 1'b0) $display("FAIL mid_rst_tlast got %b want 0", out_tlast); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    drive_field(4'd15, 3'b100, 64'd0, 1'b1);
    collect(40);
    checks++; if (got_data.size() != 2) $display("FAIL mid_after_count got %0d want 2", got_data.size()); else passed++;
    if (got_data.size() == 2) begin
      checks++; if (got_data[0] !== 8'h78) $display("FAIL mid_after_b0 got %h want 78", got_data[0]); else passed++;
      checks++; if (got_data[1] !== 8'h00) $display("FAIL mid_after_b1 got %h want 00", got_data[1]); else passed++;
      checks++; if (got_last[0] !== 1'b0 || got_last[1] !== 1'b1) $display("FAIL mid_after_tlast got %b%b want 01", got_last[0], got_last[1]); else passed++;
    end
  endtask

  task automatic test_unsupported();
    logic [2:0] bad[3] = '{3'b011, 3'b110, 3'b111};
    for (int k = 0; k < 3; k++) begin
      drive_field(4'd5, bad[k], 64'd1, 1'b1);
      checks++; if (field_err !== 1'b1) $display("FAIL err%0d_pulse got %b want 1", k, field_err); else passed++;
      checks++; if (out_tvalid !== 1'b0) $display("FAIL err%0d_tvalid got %b want 0", k, out_tvalid); else passed++;
      checks++; if (field_ready !== 1'b1) $display("FAIL err%0d_ready got %b want 1", k, field_ready); else passed++;
      @(negedge clk);
      checks++; if (field_err !== 1'b0) $display("FAIL err%0d_single got %b want 0", k, field_err); else passed++;
      checks++; if (out_tvalid !== 1'b0) $display("FAIL err%0d_tvalid2 got %b want 0", k, out_tvalid); else passed++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    field_valid = 1'b0; field_id = 4'd0; field_type = 3'd0;
    field_value = 64'd0; field_last = 1'b0;
    out_tready = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_encodings();
    test_backpressure();
    test_reset_mid();
    test_unsupported();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
